// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle: bit stream toward the deserializer,
// assembled words and status flags back out.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
) ();
  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             overrun;
  logic             framing_err;
  logic             clear_flags;

  // Driver side: produces the bit stream, consumes words, clears flags.
  modport master (
    output serial_in, bit_valid, frame_start, data_ready, clear_flags,
    input  data_out, data_valid, busy, overrun, framing_err
  );

  // Deserializer side.
  modport slave (
    input  serial_in, bit_valid, frame_start, data_ready, clear_flags,
    output data_out, data_valid, busy, overrun, framing_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with a single-word output
// register on a valid/ready handshake, plus sticky overrun and framing flags.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  sipo_deserializer_if.slave  bus
);

  localparam int          CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             ferr_reg, ferr_next;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_one;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             ferr_evt;
  logic             ov_evt;

  // State register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      ferr_reg    <= ferr_next;
    end
  end

  // Next-state: bit assembly, word completion, handshake and flag updates.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    complete   = 1'b0;
    word       = '0;
    ferr_evt   = 1'b0;
    ov_evt     = 1'b0;

    // Concatenating one bit past the register lets WIDTH==1 share the path.
    ext         = {shift_reg, bus.serial_in};
    shifted     = ext[WIDTH-1:0];
    load_one    = '0;
    load_one[0] = bus.serial_in;

    if (bus.bit_valid) begin
      case (state_reg)
        IDLE: begin
          if (bus.frame_start) begin
            if (WIDTH == 1) begin
              complete = 1'b1;
              word     = load_one;
            end else begin
              shift_next = load_one;
              cnt_next   = CW'(1);
              state_next = SHIFT;
            end
          end
        end
        SHIFT: begin
          if (bus.frame_start) begin
            // Resync: the partial word is thrown away, never surfaced.
            shift_next = load_one;
            cnt_next   = CW'(1);
            ferr_evt   = 1'b1;
          end else if (cnt_reg == LAST) begin
            complete   = 1'b1;
            word       = shifted;
            shift_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            shift_next = shifted;
            cnt_next   = cnt_reg + CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    data_next  = data_reg;
    valid_next = valid_reg;
    if (complete) begin
      // A same-edge consume frees the register, so the new word fits.
      if (!valid_reg || bus.data_ready) begin
        data_next  = word;
        valid_next = 1'b1;
      end else begin
        ov_evt = 1'b1;
      end
    end else if (valid_reg && bus.data_ready) begin
      valid_next = 1'b0;
    end

    // A new event beats a coincident clear.
    overrun_next = (overrun_reg && !bus.clear_flags) || ov_evt;
    ferr_next    = (ferr_reg && !bus.clear_flags) || ferr_evt;
  end

  assign bus.data_out    = data_reg;
  assign bus.data_valid  = valid_reg;
  assign bus.busy        = (state_reg == SHIFT);
  assign bus.overrun     = overrun_reg;
  assign bus.framing_err = ferr_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_sipo_deserializer;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sipo_deserializer_if #(.WIDTH(WIDTH)) bus ();

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the current frame in a queue, one output slot.
  bit             q[$];
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_valid = 1'b0;
  logic             m_ov    = 1'b0;
  logic             m_ferr  = 1'b0;
  bit               live    = 0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] w;
    bit done, ov_e, fe_e;
    done = 0; ov_e = 0; fe_e = 0; w = '0;
    if (rst) begin
      q.delete();
      m_data = '0; m_valid = 1'b0; m_ov = 1'b0; m_ferr = 1'b0;
      live = 1;
    end else begin
      if (bus.bit_valid) begin
        if (bus.frame_start) begin
          if (q.size() > 0) fe_e = 1;
          q.delete();
          q.push_back(bus.serial_in);
        end else if (q.size() > 0) begin
          q.push_back(bus.serial_in);
        end
        if (q.size() == WIDTH) begin
          foreach (q[i]) w = {w[WIDTH-2:0], q[i]};
          done = 1;
          q.delete();
        end
      end
      if (done) begin
        if (!m_valid || bus.data_ready) begin
          m_data = w; m_valid = 1'b1;
        end else ov_e = 1;
      end else if (m_valid && bus.data_ready) m_valid = 1'b0;
      if (bus.clear_flags) begin m_ov = 1'b0; m_ferr = 1'b0; end
      if (ov_e) m_ov = 1'b1;
      if (fe_e) m_ferr = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (live) begin
      checks++;
      if (bus.data_out !== m_data || bus.data_valid !== m_valid ||
          bus.busy !== (q.size() > 0) || bus.overrun !== m_ov ||
          bus.framing_err !== m_ferr) begin
        failures++;
        $display("FAIL model t=%0t actual d=%h v=%b b=%b ov=%b fe=%b required d=%h v=%b b=%b ov=%b fe=%b",
                 $time, bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.framing_err,
                 m_data, m_valid, (q.size() > 0), m_ov, m_ferr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitx(input logic b, input logic fs);
    bus.bit_valid   = 1'b1;
    bus.serial_in   = b;
    bus.frame_start = fs;
    @(negedge clk);
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.serial_in   = 1'b0;
  endtask

  task automatic word4(input logic [3:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      bitx(w[i], i == 3);
      if (i != 0) cyc(gap);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.serial_in = 1'b0; bus.bit_valid = 1'b0; bus.frame_start = 1'b0;
    bus.data_ready = 1'b0; bus.clear_flags = 1'b0;
    cyc(2);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_valid", bus.data_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_flags", {bus.overrun, bus.framing_err}, 0);
    rst = 1'b0;
    cyc(1);

    // MSB-first assembly with latency 1.
    bus.data_ready = 1'b1;
    bitx(1'b1, 1'b1); chk("t1_busy_b1", bus.busy, 1);
    bitx(1'b0, 1'b0); chk("t1_busy_b2", bus.busy, 1);
    bitx(1'b1, 1'b0); chk("t1_busy_b3", bus.busy, 1);
    bitx(1'b1, 1'b0);
    chk("t1_busy_done", bus.busy, 0);
    chk("t1_data", bus.data_out, 4'b1011);
    chk("t1_valid", bus.data_valid, 1);
    cyc(1);
    chk("t1_consumed", bus.data_valid, 0);
    chk("t1_data_kept", bus.data_out, 4'b1011);

    // Gapped bits, busy held through gaps.
    bus.data_ready = 1'b0;
    bitx(1'b1, 1'b1); cyc(2); chk("t2_busy_gap", bus.busy, 1);
    bitx(1'b0, 1'b0); cyc(2);
    bitx(1'b1, 1'b0); cyc(2); chk("t2_busy_gap3", bus.busy, 1);
    bitx(1'b1, 1'b0);
    chk("t2_data", bus.data_out, 4'b1011);
    chk("t2_flags", {bus.overrun, bus.framing_err}, 0);
    bus.data_ready = 1'b1; cyc(1);
    chk("t2_consumed", bus.data_valid, 0);

    // Back-pressure and overrun.
    bus.data_ready = 1'b0;
    word4(4'b1100, 0);
    word4(4'b0011, 0);
    chk("t3_data_held", bus.data_out, 4'b1100);
    chk("t3_overrun", bus.overrun, 1);
    bus.data_ready = 1'b1; cyc(1);
    chk("t3_consumed", bus.data_valid, 0);
    bus.data_ready = 1'b0; bus.clear_flags = 1'b1; cyc(1);
    bus.clear_flags = 1'b0;
    chk("t3_cleared", bus.overrun, 0);

    // Completion and consume on the same edge.
    word4(4'b1010, 0);
    bitx(1'b0, 1'b1); bitx(1'b1, 1'b0); bitx(1'b0, 1'b0);
    bus.data_ready = 1'b1;
    bitx(1'b1, 1'b0);
    chk("t4_data", bus.data_out, 4'b0101);
    chk("t4_valid", bus.data_valid, 1);
    chk("t4_no_overrun", bus.overrun, 0);
    cyc(1);

    // Resync mid-word, then a stray bit in IDLE.
    bitx(1'b1, 1'b1); bitx(1'b1, 1'b0);
    bitx(1'b0, 1'b1); bitx(1'b0, 1'b0); bitx(1'b1, 1'b0); bitx(1'b1, 1'b0);
    chk("t5_ferr", bus.framing_err, 1);
    chk("t5_data", bus.data_out, 4'b0011);
    bitx(1'b1, 1'b0);
    chk("t5_stray_busy", bus.busy, 0);
    chk("t5_stray_data", bus.data_out, 4'b0011);
    chk("t5_stray_valid", bus.data_valid, 0);

    // Reset mid-word with a word pending.
    bus.data_ready = 1'b0;
    word4(4'b1111, 0);
    bitx(1'b1, 1'b1); bitx(1'b0, 1'b0);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("t6_rst_outputs", {bus.data_out, bus.data_valid, bus.busy, bus.overrun, bus.framing_err}, 0);
    bus.data_ready = 1'b1;
    word4(4'b1001, 0);
    chk("t6_data", bus.data_out, 4'b1001);
    chk("t6_valid", bus.data_valid, 1);

    // Clear coinciding with a new framing event leaves the flag set.
    bitx(1'b1, 1'b1);
    bus.clear_flags = 1'b1;
    bitx(1'b0, 1'b1);
    bus.clear_flags = 1'b0;
    chk("t7_ferr_wins", bus.framing_err, 1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Receives an MSB-first serial bit stream, such as the output of the team's 4-bit PISO shift register, and assembles it into WIDTH-bit parallel words.
- Completed words are held in an output register and offered downstream over a valid/ready handshake.
- Sticky flags report words dropped for lack of downstream space (overrun) and frames restarted before completion (framing error).

Parameters:
- WIDTH, 4, bits per word; legal range 1..32.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- serial_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- frame_start  input  1  marks the current valid bit as the first (MSB) bit of a word; ignored when bit_valid=0.
- data_out  output  WIDTH  assembled word; first received bit lands in data_out[WIDTH-1].
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  downstream accepts data_out when data_valid=1.
- busy  output  1  high while a word is partially received (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped.
- framing_err  output  1  sticky: frame_start arrived mid-word.
- clear_flags  input  1  clears overrun and framing_err.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; shift register=0; bit counter=0.
  - data_out=0, data_valid=0, busy=0, overrun=0, framing_err=0.
  - Reset overrides every other input, including mid-word and with a word pending.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- Accepted bit = bit_valid=1 at a rising edge. Accepting a bit shifts the register left, inserting serial_in at the LSB.
- IDLE:
  - Accepted bit with frame_start=1: load it as bit 1, counter=1, go to SHIFT.
  - If WIDTH==1, the word completes on that same edge and the state stays IDLE.
  - Accepted bits with frame_start=0 are discarded and no flag is set.
- SHIFT, accepted bit with frame_start=0: shift it in and increment the counter.
- SHIFT, accepted bit with frame_start=1 (resync): discard the partial word, load this bit as bit 1, counter=1, set framing_err; state stays SHIFT.
- SHIFT, bit_valid=0: hold all state; there is no timeout.
- Word completion:
  - Occurs on the edge accepting bit WIDTH.
  - The completed value is {shift_reg[WIDTH-2:0], serial_in}. It is written to data_out on that same edge, so data_valid rises in the cycle after the last bit is sampled (latency 1 clock).
  - Counter returns to 0 and state to IDLE.
- Output handshake:
  - Consume = data_valid && data_ready at an edge. It clears data_valid unless a completion occurs on the same edge.
  - Completion while data_valid=0: load data_out, data_valid=1.
  - Completion together with a consume on the same edge: load the new word, data_valid stays 1; no overrun.
  - Completion while data_valid=1 and data_ready=0: drop the new word, keep data_out unchanged, set overrun.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_out keeps its last value after a consume; it is not zeroed.
- Flags:
  - Both flags are sticky until clear_flags=1 or rst.
  - If clear_flags coincides with a new overrun or framing event, the flag ends up set.
- Width rules:
  - Bit counter is wide enough to hold WIDTH.
  - No bit from a resynced or dropped word ever appears on data_out.

Test Plan:
- MSB-first assembly, WIDTH=4: frame_start+1, then 0, 1, 1 on consecutive cycles, data_ready=1 -> data_out=4'b1011 with data_valid=1 one cycle after the 4th bit; busy high for 3 cycles.
- Gapped input: same bits with bit_valid low for 2 cycles between each bit -> data_out=4'b1011, no flags set, busy stays high throughout the gaps.
- Back-pressure:
  - Stimulus: word 4'b1100 completes with data_ready=0; a second word 4'b0011 completes while data_ready is still 0.
  - Required: data_out stays 4'b1100; overrun=1.
  - Then data_ready=1 -> consumed, data_valid=0.
  - Then clear_flags -> overrun=0.
- Back-to-back with consume on the same edge: word A=4'b1010 is pending and data_ready=1 on the edge word B=4'b0101 completes -> data_out=4'b0101, data_valid stays 1, overrun=0.
- Resync:
  - Stimulus: frame_start+1, 1, then frame_start+0, followed by 0, 1, 1.
  - Required: framing_err=1; data_out=4'b0011; the partial bits never appear.
  - A stray bit in IDLE without frame_start is ignored.
- Reset mid-word and with a word pending: rst after 2 bits while data_valid=1 -> all outputs 0, state IDLE; the next clean frame 4'b1001 assembles correctly.
